// File: rtl/enforcer_pack.sv
// Shared types and constants for the Avalon-ST packet enforcement blocks.
package enforcer_pack;

   typedef enum logic [0:0] {
      IDLE,
      SEND
   } packetizer_sm_t;

   localparam int unsigned DEFAULT_DATA_WIDTH_IN_BYTES = 16;
   localparam int unsigned EMPTY_WIDTH                 = $clog2(DEFAULT_DATA_WIDTH_IN_BYTES);

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST packet interface: data/valid/sop/eop/empty forward, rdy backward.
interface avalon_st_if
   import enforcer_pack::*;
#(
   parameter int unsigned DATA_WIDTH_IN_BYTES = DEFAULT_DATA_WIDTH_IN_BYTES
);
   localparam int unsigned EW = $clog2(DATA_WIDTH_IN_BYTES);

   logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
   logic                             valid;
   logic                             sop;
   logic                             eop;
   logic [EW-1:0]                    empty;
   logic                             rdy;

   modport master (
      output data, valid, sop, eop, empty,
      input  rdy
   );

   modport slave (
      input  data, valid, sop, eop, empty,
      output rdy
   );

endinterface

// File: rtl/avalon_len_calc.sv
// Byte length to beat count and unused-byte count of the final beat.
module avalon_len_calc
   import enforcer_pack::*;
#(
   parameter int unsigned DATA_WIDTH_IN_BYTES = DEFAULT_DATA_WIDTH_IN_BYTES,
   parameter int unsigned LEN_WIDTH           = 16,
   localparam int unsigned EW                 = $clog2(DATA_WIDTH_IN_BYTES)
) (
   input  logic [LEN_WIDTH-1:0] len_bytes,
   output logic [LEN_WIDTH-1:0] word_count,
   output logic [EW-1:0]        last_empty
);

   // One extra bit so the round-up add cannot wrap at the maximum length.
   logic [LEN_WIDTH:0] sum;

   always_comb begin
      sum        = {1'b0, len_bytes} + (LEN_WIDTH+1)'(DATA_WIDTH_IN_BYTES - 1);
      word_count = LEN_WIDTH'(sum >> EW);
      last_empty = EW'(0) - len_bytes[EW-1:0];
   end

endmodule

// File: rtl/avalon_packetizer.sv
// Frames a raw word stream into Avalon-ST packets from per-packet byte-length commands.
module avalon_packetizer
   import enforcer_pack::*;
#(
   parameter int unsigned DATA_WIDTH_IN_BYTES = DEFAULT_DATA_WIDTH_IN_BYTES,
   parameter int unsigned LEN_WIDTH           = 16,
   localparam int unsigned EW                 = $clog2(DATA_WIDTH_IN_BYTES)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             len_valid,
   input  logic [LEN_WIDTH-1:0]             len_bytes,
   output logic                             len_rdy,
   input  logic                             raw_valid,
   input  logic [8*DATA_WIDTH_IN_BYTES-1:0] raw_data,
   output logic                             raw_rdy,
   avalon_st_if.master                      framed_msg,
   output logic                             len_error,
   output logic                             busy
);

   packetizer_sm_t       state_q;
   logic [LEN_WIDTH-1:0] words_left_q;
   logic [EW-1:0]        last_empty_q;
   logic                 first_word_q;
   logic                 len_error_q;

   logic [LEN_WIDTH-1:0] calc_words;
   logic [EW-1:0]        calc_empty;
   logic                 last_word;
   logic                 beat;

   avalon_len_calc #(
      .DATA_WIDTH_IN_BYTES (DATA_WIDTH_IN_BYTES),
      .LEN_WIDTH           (LEN_WIDTH)
   ) u_len_calc (
      .len_bytes  (len_bytes),
      .word_count (calc_words),
      .last_empty (calc_empty)
   );

   assign last_word = (words_left_q == LEN_WIDTH'(1));
   assign beat      = (state_q == SEND) && raw_valid && framed_msg.rdy;
   assign len_rdy   = (state_q == IDLE);
   assign busy      = (state_q == SEND);
   assign len_error = len_error_q;

   // Zero-latency pass-through; every framed field is forced to 0 when not valid.
   always_comb begin
      framed_msg.valid = 1'b0;
      framed_msg.data  = '0;
      framed_msg.sop   = 1'b0;
      framed_msg.eop   = 1'b0;
      framed_msg.empty = '0;
      raw_rdy          = 1'b0;
      if (state_q == SEND) begin
         raw_rdy          = framed_msg.rdy;
         framed_msg.valid = raw_valid;
         if (raw_valid) begin
            framed_msg.data  = raw_data;
            framed_msg.sop   = first_word_q;
            framed_msg.eop   = last_word;
            framed_msg.empty = last_word ? last_empty_q : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         words_left_q <= '0;
         last_empty_q <= '0;
         first_word_q <= 1'b0;
         len_error_q  <= 1'b0;
      end else begin
         len_error_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (len_valid) begin
                  if (len_bytes == '0) begin
                     len_error_q <= 1'b1;
                  end else begin
                     words_left_q <= calc_words;
                     last_empty_q <= calc_empty;
                     first_word_q <= 1'b1;
                     state_q      <= SEND;
                  end
               end
            end
            SEND: begin
               if (beat) begin
                  first_word_q <= 1'b0;
                  words_left_q <= words_left_q - LEN_WIDTH'(1);
                  if (last_word) begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_packetizer.sv
// Scoreboard bench for avalon_packetizer with B=16 byte beats.
module tb_avalon_packetizer;
   import enforcer_pack::*;

   localparam int unsigned B  = 16;
   localparam int unsigned LW = 16;

   typedef struct packed {
      logic [8*B-1:0]         data;
      logic                   sop;
      logic                   eop;
      logic [EMPTY_WIDTH-1:0] empty;
   } beat_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           len_valid = 1'b0;
   logic [LW-1:0]  len_bytes = '0;
   logic           len_rdy;
   logic           raw_valid = 1'b0;
   logic [8*B-1:0] raw_data = '0;
   logic           raw_rdy;
   logic           len_error;
   logic           busy;

   avalon_st_if #(.DATA_WIDTH_IN_BYTES(B)) framed ();

   avalon_packetizer #(
      .DATA_WIDTH_IN_BYTES (B),
      .LEN_WIDTH           (LW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .len_valid  (len_valid),
      .len_bytes  (len_bytes),
      .len_rdy    (len_rdy),
      .raw_valid  (raw_valid),
      .raw_data   (raw_data),
      .raw_rdy    (raw_rdy),
      .framed_msg (framed),
      .len_error  (len_error),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_pass   = 0;
   beat_t exp_q[$];
   int    busy_cycles  = 0;
   int    err_cycles   = 0;
   int    valid_cycles = 0;

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (busy) busy_cycles++;
      if (len_error) err_cycles++;
      if (framed.valid) valid_cycles++;
      if (framed.valid && framed.rdy) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("data", framed.data, e.data);
            check("sop", framed.sop, e.sop);
            check("eop", framed.eop, e.eop);
            check("empty", framed.empty, e.empty);
         end
      end
   end

   task automatic wait_len_rdy();
      int t = 0;
      while (!len_rdy && t < 16) begin
         @(posedge clk); #1;
         t++;
      end
      if (!len_rdy) check("len_rdy_timeout", 0, 1);
   endtask

   task automatic issue_cmd(input int len);
      wait_len_rdy();
      len_valid = 1'b1;
      len_bytes = LW'(len);
      @(posedge clk); #1;
      len_valid = 1'b0;
   endtask

   // Drive beats [first, last) of an accepted packet of len bytes.
   task automatic drive_beats(input int len, input int first, input int last,
                              input int stall_beat, input int stall_cycles);
      int    n;
      beat_t e;
      n = (len + B - 1) / B;
      for (int i = first; i < last; i++) begin
         int t;
         e.data  = {$urandom, $urandom, $urandom, $urandom};
         e.sop   = (i == 0);
         e.eop   = (i == n - 1);
         e.empty = e.eop ? EMPTY_WIDTH'((B - (len % B)) % B) : '0;
         exp_q.push_back(e);
         raw_valid = 1'b1;
         raw_data  = e.data;
         if (i == stall_beat) begin
            framed.rdy = 1'b0;
            for (int s = 0; s < stall_cycles; s++) begin
               @(negedge clk);
               check("stall_raw_rdy", raw_rdy, 0);
               check("stall_hold", framed.data, e.data);
               @(posedge clk); #1;
            end
            framed.rdy = 1'b1;
         end
         t = 0;
         @(negedge clk);
         while (!raw_rdy && t < 8) begin
            @(negedge clk);
            t++;
         end
         if (!raw_rdy) check("raw_rdy_timeout", 0, 1);
         @(posedge clk); #1;
      end
      raw_valid = 1'b0;
      raw_data  = '0;
   endtask

   initial begin
      framed.rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_len_rdy", len_rdy, 1);
      check("rst_valid", framed.valid, 0);
      check("rst_raw_rdy", raw_rdy, 0);
      check("rst_len_error", len_error, 0);
      check("rst_busy", busy, 0);

      // 40 bytes: 3 beats, empty 8 on eop
      issue_cmd(40);
      check("send_len_rdy", len_rdy, 0);
      drive_beats(40, 0, 3, -1, 0);
      check("after_len_rdy", len_rdy, 1);
      check("after_busy", busy, 0);

      // 16 bytes: single beat, busy for one cycle
      @(posedge clk); #1;
      busy_cycles = 0;
      issue_cmd(16);
      drive_beats(16, 0, 1, -1, 0);
      @(posedge clk); #1;
      check("single_busy_cycles", busy_cycles, 1);

      // Zero length, then back-to-back zero lengths
      err_cycles = 0;
      valid_cycles = 0;
      issue_cmd(0);
      @(negedge clk);
      check("zero_len_rdy", len_rdy, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("zero_err_cycles", err_cycles, 1);
      check("zero_no_valid", valid_cycles, 0);
      err_cycles = 0;
      len_valid = 1'b1;
      len_bytes = '0;
      repeat (2) @(posedge clk);
      #1;
      len_valid = 1'b0;
      @(negedge clk);
      check("b2b_err_second", len_error, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("b2b_err_cycles", err_cycles, 2);

      // 48 bytes with a two-cycle stall on the second beat
      issue_cmd(48);
      drive_beats(48, 0, 3, 1, 2);
      check("stall_done_len_rdy", len_rdy, 1);

      // 64 bytes truncated by reset after the first beat, then 17 bytes
      issue_cmd(64);
      drive_beats(64, 0, 1, -1, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("trunc_valid", framed.valid, 0);
      check("trunc_len_rdy", len_rdy, 1);
      check("trunc_busy", busy, 0);
      issue_cmd(17);
      drive_beats(17, 0, 2, -1, 0);

      // Maximum length
      issue_cmd(65535);
      drive_beats(65535, 0, 4096, -1, 0);
      @(posedge clk); #1;
      check("max_len_rdy", len_rdy, 1);
      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/avalon_packetizer.md
# avalon_packetizer

Source-side framer for the Avalon-ST packet interface (`avalon_st_if`). It takes a per-packet byte-length command and a raw, unframed word stream, and drives well-formed packets: exactly one `sop` on the first word, exactly one `eop` on the last word, and a correct `empty` on `eop`. It sits upstream of the packet checker, so any stream it emits passes that checker with zero error indications.

## Interface
Parameters:
- `DATA_WIDTH_IN_BYTES`, default 16: bytes per beat; must be a power of 2, at least 2.
- `LEN_WIDTH`, default 16: width of the length command; maximum packet length is 2^LEN_WIDTH−1 bytes.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `len_valid`  in  1  length command valid.
- `len_bytes`  in  LEN_WIDTH  packet length in bytes.
- `len_rdy`  out  1  command accepted when `len_valid & len_rdy`.
- `raw_valid`  in  1  raw data word valid.
- `raw_data`  in  8*DATA_WIDTH_IN_BYTES  raw payload word.
- `raw_rdy`  out  1  raw word consumed when `raw_valid & raw_rdy`.
- `framed_msg`  `avalon_st_if.master`  framed output (`data`, `valid`, `sop`, `eop`, `empty` out; `rdy` in). `empty` is $clog2(DATA_WIDTH_IN_BYTES) bits.
- `len_error`  out  1  one-cycle pulse when a zero-length command is received and dropped.
- `busy`  out  1  high while a packet is in progress.

## Operation
- FSM states, typedef `packetizer_sm_t`: IDLE, SEND.
- IDLE:
  - `len_rdy`=1, `raw_rdy`=0, all `framed_msg` outputs 0.
  - On `len_valid` with `len_bytes`==0: pulse `len_error` in the next cycle and stay in IDLE.
  - On `len_valid` with `len_bytes`>0: latch `words_left` = ceil(`len_bytes`/B) and `last_empty` = (B − `len_bytes` mod B) mod B, where B = DATA_WIDTH_IN_BYTES. Set `first_word`=1 and go to SEND.
  - Compute ceil(`len_bytes`/B) as (`len_bytes` + B − 1) >> log2(B) at LEN_WIDTH+1 bits, so there is no overflow at the maximum length.
- SEND:
  - `len_rdy`=0 and `busy`=1.
  - Data path is combinational pass-through: `framed_msg.valid`=`raw_valid`, `framed_msg.data`=`raw_data`, `raw_rdy`=`framed_msg.rdy`.
  - `sop` = `first_word & raw_valid`.
  - `eop` = (`words_left`==1) `& raw_valid`.
  - `empty` = `eop` ? `last_empty` : 0.
  - On a beat transfer (`raw_valid & framed_msg.rdy`): clear `first_word` and decrement `words_left`. If `words_left` was 1, return to IDLE.
- While `framed_msg.valid`=0, `data`, `sop`, `eop` and `empty` are all driven 0. No X is ever driven.
- A single-word packet asserts `sop` and `eop` on the same beat.
- `len_valid` in SEND is ignored; the command is held by the upstream source until IDLE.

## Timing
- Reset value of every output is 0 except `len_rdy`, which is 1 because the block resets into IDLE.
- Latency from a command accept to the first beat's earliest transfer is 1 cycle.
- Raw-to-framed data latency is 0 cycles.
- There is 1 idle cycle between packets, because the next command is accepted only in IDLE. Maximum throughput is L words per L+1 cycles.
- Backpressure: while `framed_msg.rdy`=0, `raw_rdy`=0. The framed outputs follow the held raw word, and no beat is lost or duplicated.
- `rst` asserted mid-packet:
  - Next cycle the block is in IDLE, all counters are cleared, `framed_msg.valid`=0 and `len_rdy`=1.
  - The partial packet is truncated without an `eop`, which is the documented downstream consequence.
- `len_error` is registered and asserted for exactly 1 cycle per zero-length command. Back-to-back zero-length commands give consecutive pulses.

## Structure
- Shared package `enforcer_pack` holds:
  - the `packetizer_sm_t` typedef;
  - the default DATA_WIDTH_IN_BYTES constant;
  - an EMPTY_WIDTH constant equal to $clog2(DATA_WIDTH_IN_BYTES).
- One combinational sub-module, `avalon_len_calc`: input `len_bytes`; outputs word count and `last_empty`. It is reused by any later length-aware block.

## Test plan
All scenarios use B=16.
- `len_bytes`=40, raw words W0–W2, `rdy`=1 → 3 beats; `sop` on W0, `eop` on W2 with `empty`=8; `len_rdy` returns to 1 the cycle after W2.
- `len_bytes`=16 → 1 beat with `sop`=`eop`=1 and `empty`=0; `busy` is high for exactly 1 cycle.
- `len_bytes`=0 → `len_error` high for exactly 1 cycle; no `framed_msg.valid`; `len_rdy` stays 1.
- `len_bytes`=48 with `framed_msg.rdy` low for 2 cycles on the second beat → W1 held stable, `raw_rdy`=0 during the stall; exactly 3 beats with `eop` on W2 and `empty`=0.
- `len_bytes`=64, `rst` after the first beat → next cycle `valid`=0 and `len_rdy`=1. Then `len_bytes`=17 → 2 beats with `eop` `empty`=15.
- `len_bytes`=65535 → 4096 beats; `sop` on beat 0 only, `eop` on beat 4095 with `empty`=1.
